// File: rtl/sram_arbiter_if.sv
// Signal bundle between two requesters, the arbiter and a single-port SRAM.
interface sram_arbiter_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  req_a;
  logic                  req_b;
  logic                  we_a;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [WIDTH-1:0]      wdata_a;
  logic [WIDTH-1:0]      wdata_b;
  logic                  gnt_a;
  logic                  gnt_b;
  logic                  rvalid_a;
  logic                  rvalid_b;
  logic [WIDTH-1:0]      rdata_a;
  logic [WIDTH-1:0]      rdata_b;
  logic                  busy;
  logic                  mem_chip_sel;
  logic                  mem_read_ena;
  logic                  mem_write_ena;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [WIDTH-1:0]      mem_data_in;
  logic [WIDTH-1:0]      mem_data_out;

  // Handshake: req_x acts as valid and gnt_x as the one-cycle accept; the
  // requester holds req_x, we_x, addr_x and wdata_x stable until it sees
  // gnt_x, and a req_x still high after gnt_x is a fresh transaction.
  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  mem_data_out,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, busy,
    output mem_chip_sel, mem_read_ena, mem_write_ena, mem_address, mem_data_in
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output mem_data_out,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, busy,
    input  mem_chip_sel, mem_read_ena, mem_write_ena, mem_address, mem_data_in
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter giving two requesters access to one SRAM with
// registered command outputs and 1-cycle read-data latency.
module sram_arbiter #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;    // 0: A wins a tie, 1: B wins
  logic                  owner_q, owner_d;  // 1 when B owns the transaction
  logic                  gnt_a_q, gnt_a_d;
  logic                  gnt_b_q, gnt_b_d;
  logic                  rvalid_a_q, rvalid_a_d;
  logic                  rvalid_b_q, rvalid_b_d;
  logic                  cs_q, cs_d;
  logic                  re_q, re_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      din_q, din_d;
  logic                  pick_b;
  logic                  pick_we;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    cs_d       = 1'b0;
    re_d       = 1'b0;
    we_d       = 1'b0;
    addr_d     = '0;
    din_d      = '0;
    pick_b     = 1'b0;
    pick_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          pick_b  = bus.req_b && (!bus.req_a || prio_q);
          pick_we = pick_b ? bus.we_b : bus.we_a;
          owner_d = pick_b;
          prio_d  = !pick_b;
          gnt_a_d = !pick_b;
          gnt_b_d = pick_b;
          cs_d    = 1'b1;
          we_d    = pick_we;
          re_d    = !pick_we;
          addr_d  = pick_b ? bus.addr_b : bus.addr_a;
          if (pick_we) din_d = pick_b ? bus.wdata_b : bus.wdata_a;
          state_d = CMD;
        end
      end
      CMD: begin
        // The SRAM samples the command at the end of this cycle; its read
        // data appears during RDATA, so rvalid is registered here.
        rvalid_a_d = re_q && !owner_q;
        rvalid_b_d = re_q && owner_q;
        state_d    = re_q ? RDATA : IDLE;
      end
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      cs_q       <= 1'b0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      cs_q       <= cs_d;
      re_q       <= re_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  assign bus.gnt_a         = gnt_a_q;
  assign bus.gnt_b         = gnt_b_q;
  assign bus.rvalid_a      = rvalid_a_q;
  assign bus.rvalid_b      = rvalid_b_q;
  assign bus.rdata_a       = rvalid_a_q ? bus.mem_data_out : '0;
  assign bus.rdata_b       = rvalid_b_q ? bus.mem_data_out : '0;
  assign bus.busy          = (state_q != IDLE);
  assign bus.mem_chip_sel  = cs_q;
  assign bus.mem_read_ena  = re_q;
  assign bus.mem_write_ena = we_q;
  assign bus.mem_address   = addr_q;
  assign bus.mem_data_in   = din_q;
  assign state_dbg         = state_q;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of SRAM words.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 req_a / req_b  input  1 each  requester A / B transaction request.
REQ-007 we_a / we_b  input  1 each  1 = write, 0 = read, qualified by req_x.
REQ-008 addr_a / addr_b  input  ADDR_WIDTH each  requester word address.
REQ-009 wdata_a / wdata_b  input  WIDTH each  requester write data.
REQ-010 gnt_a / gnt_b  output  1 each  one-cycle grant pulse, command issued to SRAM.
REQ-011 rvalid_a / rvalid_b  output  1 each  one-cycle read-data-valid pulse.
REQ-012 rdata_a / rdata_b  output  WIDTH each  read data, valid only with rvalid_x.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 mem_chip_sel, mem_read_ena, mem_write_ena  output  1 each  to SRAM controls.
REQ-015 mem_address  output  ADDR_WIDTH  to SRAM address.
REQ-016 mem_data_in  output  WIDTH  to SRAM write data.
REQ-017 mem_data_out  input  WIDTH  from SRAM registered read data (1-cycle latency, 0 when not reading).

Function
REQ-018 FSM states SHALL be IDLE, CMD, RDATA; encoding free.
REQ-019 req_x, we_x, addr_x, wdata_x SHALL be sampled only in IDLE; values in other states are ignored.
REQ-020 IDLE with no req SHALL stay IDLE with all mem_* outputs 0.
REQ-021 IDLE with exactly one req SHALL grant that requester and go to CMD.
REQ-022 IDLE with both req SHALL grant the requester indicated by the round-robin pointer prio and go to CMD.
REQ-023 prio SHALL point to the non-granted requester after every grant (toggles only when a grant occurs).
REQ-024 On IDLE->CMD the block SHALL register mem_chip_sel=1, mem_write_ena=we_x, mem_read_ena=~we_x, mem_address=addr_x, mem_data_in=wdata_x (winner's fields; mem_data_in=0 for reads).
REQ-025 mem_read_ena and mem_write_ena SHALL never be 1 in the same cycle.
REQ-026 gnt_x SHALL be 1 for exactly the CMD cycle of requester x's transaction; gnt_a and gnt_b never both 1.
REQ-027 CMD SHALL last one cycle; write -> IDLE, read -> RDATA; all mem_* outputs return to 0 on leaving CMD.
REQ-028 RDATA SHALL last one cycle, assert rvalid_x for the read's owner only, then go to IDLE.
REQ-029 rdata_x SHALL equal mem_data_out while rvalid_x=1 and 0 otherwise.
REQ-030 Latency from req sampled in IDLE (cycle 0): gnt in cycle 1; read data/rvalid in cycle 2; next sample in cycle 2 (write) or cycle 3 (read).
REQ-031 A requester SHALL hold req_x and its fields stable until gnt_x; a req held high past gnt_x into the next IDLE SHALL be treated as a new transaction.
REQ-032 With both requesters continuously requesting, grants SHALL strictly alternate A,B,A,B (no starvation).

Reset
REQ-033 reset=0 SHALL immediately, independent of clk, force state IDLE, prio=A, and all outputs to 0.
REQ-034 Reset asserted mid-transaction SHALL abort it with no gnt/rvalid pulse issued afterwards; the SRAM write already sampled is not undone.
REQ-035 After reset deasserts, the first rising edge with req high SHALL be treated as IDLE sampling.

Verification
REQ-036 A write addr 4 data 0xAA, then A read addr 4 -> gnt_a cycle 1, mem_write_ena=1 mem_address=4 mem_data_in=0xAA; read gives rvalid_a with rdata_a=0xAA two cycles after req sampled.
REQ-037 Both req in same cycle after reset (A write addr 6 0x25, B write addr 1 0xFF) -> gnt_a first, gnt_b two cycles later; B reads addr 1 -> 0xFF, A reads addr 6 -> 0x25.
REQ-038 Both requesters hold req for 8 transactions -> grant sequence A,B,A,B,A,B,A,B; never both gnt; never both mem enables.
REQ-039 B read addr 2 while A writes addr 2 0xDA granted first -> B's rdata_b=0xDA; rvalid_a stays 0.
REQ-040 reset=0 asserted during CMD of a read -> all outputs 0 asynchronously, no rvalid follows, busy=0, next grant after release goes to A when both request.
REQ-041 No req for 10 cycles -> busy=0, all mem_* outputs 0, no gnt or rvalid.
